edge_event_queue: RTL

- Downstream consumer of the per-bit edge detector.
- Takes the registered 8-bit `anyedge` pulse vector and turns each asserted bit into a timestamped event `{bit index, time}`.
- Buffers events in a small FIFO and presents them on a valid/ready stream to the event-logging logic.
- Simultaneous edges on several bits are serialized, lowest index first.

---
 rtl/edge_evt_pkg.sv | 33 +++
 rtl/edge_event_queue_if.sv | 26 ++
 rtl/edge_evt_fifo.sv | 53 +++++
 rtl/edge_event_queue.sv | 118 +++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// rtl/edge_evt_pkg.sv - shared widths, event record type and bit-vector helpers
package edge_evt_pkg;

  localparam int N_BITS    = 8;
  localparam int IDX_W     = 3;
  localparam int EVT_TS_W  = 16;

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic [EVT_TS_W-1:0] ts;
  } evt_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_BITS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_BITS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Number of set bits (0..N_BITS).
  function automatic logic [IDX_W:0] popcount(input logic [N_BITS-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N_BITS; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/edge_event_queue_if.sv
// rtl/edge_event_queue_if.sv - valid/ready event stream between queue and logger
interface edge_event_queue_if #(
  parameter int TS_W = 16
);
  import edge_evt_pkg::IDX_W;

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_bit;
  logic [TS_W-1:0]  evt_time;

  modport master (
    output evt_valid,
    output evt_bit,
    output evt_time,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_bit,
    input  evt_time,
    output evt_ready
  );

endinterface

// File: rtl/edge_evt_fifo.sv
// rtl/edge_evt_fifo.sv - show-ahead synchronous FIFO of evt_t records
module edge_evt_fifo
  import edge_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   push,
  input  evt_t                   push_data,
  output logic                   full,
  input  logic                   pop,
  output evt_t                   head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  evt_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered level only, so a same-cycle pop never makes room.
  assign full    = (level_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Storage, power-of-two wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/edge_event_queue.sv
// rtl/edge_event_queue.sv - timestamps edge pulses and serializes them onto a stream (option: EDGE_EVT_DROP_CNT_EN adds drop_cnt)
module edge_event_queue
  import edge_evt_pkg::*;
#(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic [N_BITS-1:0]       anyedge,
  input  logic                    clr_lost,
  edge_event_queue_if.master      evt,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    lost
`ifdef EDGE_EVT_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  if (TS_W != EVT_TS_W) begin : g_ts_w_chk
    $error("edge_event_queue: TS_W must match edge_evt_pkg::EVT_TS_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("edge_event_queue: DEPTH must be a power of two >= 2");
  end

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [N_BITS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]   ts_pend_q [N_BITS];
  logic [TS_W-1:0]   ts_pend_d [N_BITS];
  logic              lost_q, lost_d;
  logic [N_BITS-1:0] grant;
  logic [N_BITS-1:0] load;
  logic [N_BITS-1:0] drop;
  logic [IDX_W-1:0]  grant_idx;
  logic              fifo_full;
  logic              fifo_empty;
  evt_t              push_data;
  evt_t              head;

  // Grant the lowest pending bit when there is room; a granted bit may re-capture in the same cycle.
  always_comb begin
    grant     = '0;
    grant_idx = lowest_idx(pending_q);
    if (pending_q != '0 && !fifo_full) grant[grant_idx] = 1'b1;
    load      = anyedge & (~pending_q | grant);
    drop      = anyedge & pending_q & ~grant;
    pending_d = (pending_q & ~grant) | load;
    for (int i = 0; i < N_BITS; i++) begin
      ts_pend_d[i] = load[i] ? ts_q : ts_pend_q[i];
    end
    ts_d   = ts_q + 1'b1;
    lost_d = lost_q;
    if (|drop)         lost_d = 1'b1;
    else if (clr_lost) lost_d = 1'b0;
  end

  assign push_data.idx = grant_idx;
  assign push_data.ts  = ts_pend_q[grant_idx];

  // Free-running timestamp, per-bit pending capture and sticky loss flag.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ts_q      <= '0;
      pending_q <= '0;
      for (int i = 0; i < N_BITS; i++) ts_pend_q[i] <= '0;
      lost_q    <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      pending_q <= pending_d;
      for (int i = 0; i < N_BITS; i++) ts_pend_q[i] <= ts_pend_d[i];
      lost_q    <= lost_d;
    end
  end

  edge_evt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .push     (|grant),
    .push_data(push_data),
    .full     (fifo_full),
    .pop      (evt.evt_ready),
    .head     (head),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_bit   = head.idx;
  assign evt.evt_time  = head.ts;
  assign lost          = lost_q;

`ifdef EDGE_EVT_DROP_CNT_EN
  logic [7:0]     drop_cnt_q, drop_cnt_d;
  logic [IDX_W:0] n_drop;
  logic [8:0]     drop_sum;

  // Saturating drop count; a clear still records the drops of its own cycle.
  always_comb begin
    n_drop     = popcount(drop);
    drop_sum   = {1'b0, drop_cnt_q} + 9'(n_drop);
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    if (clr_lost) drop_cnt_d = 8'(n_drop);
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) drop_cnt_q <= '0;
    else           drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
